// File: rtl/ro_puf_pkg.sv
// Shared widths, defaults and FSM state type for the ring-oscillator PUF
// measurement scheduler.
package ro_puf_pkg;

    localparam int unsigned NUM_RO_DEF = 9;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned CHAL_W     = 8;
    localparam int unsigned RO_CHAL_W  = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        MEASURE = 3'd2,
        SYNC    = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } ro_state_t;

endpackage

// File: rtl/ro_measure_sched.sv
// Sequences NUM_RO ring oscillators through clear/measure/settle/capture and
// derives the PUF response by comparing neighbouring edge counts.
module ro_measure_sched
    import ro_puf_pkg::*;
#(
    parameter int unsigned      NUM_RO   = NUM_RO_DEF,
    parameter logic [CNT_W-1:0] WINDOW   = 16'hFFFF,
    parameter int unsigned      SYNC_CYC = 3
) (
    input  logic                       count_clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [CHAL_W-1:0]          challenge,
    output logic [RO_CHAL_W-1:0]       ro_challenge,
    output logic [$clog2(NUM_RO)-1:0]  ro_sel,
    output logic                       ro_en,
    output logic                       cnt_clear,
    input  logic [CNT_W-1:0]           cnt_value,
    output logic [NUM_RO-2:0]          response,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SEL_W = $clog2(NUM_RO);

    ro_state_t               state, state_nxt;
    logic [CNT_W-1:0]        tmr, tmr_nxt;
    logic [SEL_W-1:0]        sel_nxt;
    logic [RO_CHAL_W-1:0]    chal_nxt;
    logic [NUM_RO-2:0]       resp_nxt;
    logic [NUM_RO-2:0]       cmp;
    logic                    cap_en;
    logic                    last_ro;
    logic [CNT_W-1:0]        result [NUM_RO];
    logic                    unused_chal_hi;

    // Only the low challenge bits steer the oscillators.
    assign unused_chal_hi = ^challenge[CHAL_W-1:RO_CHAL_W];

    assign last_ro = (ro_sel == SEL_W'(NUM_RO - 1));

    // Neighbour comparison; the last oscillator's count is still on cnt_value
    // in the cycle the response is registered.
    always_comb begin
        cmp = '0;
        for (int unsigned i = 1; i < NUM_RO; i++) begin
            if (i == NUM_RO - 1) begin
                cmp[i-1] = (cnt_value > result[i-1]);
            end else begin
                cmp[i-1] = (result[i] > result[i-1]);
            end
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        sel_nxt   = ro_sel;
        chal_nxt  = ro_challenge;
        resp_nxt  = response;
        cap_en    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = CLEAR;
                    sel_nxt   = '0;
                    chal_nxt  = challenge[RO_CHAL_W-1:0];
                    resp_nxt  = '0;
                end
            end
            CLEAR: begin
                state_nxt = MEASURE;
                tmr_nxt   = '0;
            end
            MEASURE: begin
                if (tmr == CNT_W'(WINDOW - 16'd1)) begin
                    state_nxt = SYNC;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + CNT_W'(1);
                end
            end
            SYNC: begin
                if (tmr == CNT_W'(SYNC_CYC - 1)) begin
                    state_nxt = CAPTURE;
                    tmr_nxt   = '0;
                end else begin
                    tmr_nxt = tmr + CNT_W'(1);
                end
            end
            CAPTURE: begin
                cap_en = 1'b1;
                if (last_ro) begin
                    state_nxt = DONE;
                    resp_nxt  = cmp;
                end else begin
                    state_nxt = CLEAR;
                    sel_nxt   = ro_sel + SEL_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            tmr          <= '0;
            ro_sel       <= '0;
            ro_challenge <= '0;
            response     <= '0;
            ro_en        <= 1'b0;
            cnt_clear    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            tmr          <= tmr_nxt;
            ro_sel       <= sel_nxt;
            ro_challenge <= chal_nxt;
            response     <= resp_nxt;
            ro_en        <= (state_nxt == MEASURE);
            cnt_clear    <= (state_nxt == CLEAR);
            busy         <= (state_nxt != IDLE) && (state_nxt != DONE);
            done         <= (state_nxt == DONE);
        end
    end

    // Per-oscillator capture store.
    always_ff @(posedge count_clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_RO; i++) begin
                result[i] <= '0;
            end
        end else if (cap_en) begin
            result[ro_sel] <= cnt_value;
        end
    end

endmodule

// File: doc/ro_measure_sched.md
RO_MEASURE_SCHED -- requirements
Module: ro_measure_sched

Interface
REQ-001 The block SHALL have parameter NUM_RO, default 9, giving the number of ring oscillators sequenced per run.
REQ-002 The block SHALL have parameter WINDOW, default 16'hFFFF, giving the count_clk cycles each oscillator is enabled.
REQ-003 The block SHALL have parameter SYNC_CYC, default 3, giving the idle cycles after disable before capture, for counter settle and crossing.
REQ-004 The block SHALL have port count_clk, input, 1, the block clock.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, a single-cycle run request.
REQ-007 The block SHALL have port challenge, input, 8, the challenge sampled at accepted start.
REQ-008 The block SHALL have port ro_challenge, output, 6, the latched challenge[5:0] driven to all oscillators.
REQ-009 The block SHALL have port ro_sel, output, $clog2(NUM_RO), the index of the active oscillator.
REQ-010 The block SHALL have port ro_en, output, 1, the enable for the selected oscillator.
REQ-011 The block SHALL have port cnt_clear, output, 1, the synchronous clear request to the external edge counter.
REQ-012 The block SHALL have port cnt_value, input, 16, the external edge count, stable once SYNC_CYC cycles have elapsed after ro_en falls.
REQ-013 The block SHALL have port response, output, NUM_RO-1, the comparison result.
REQ-014 The block SHALL have ports busy and done, output, 1 each, giving run status.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, MEASURE, SYNC, CAPTURE and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL latch challenge, set ro_sel=0, clear done and go to CLEAR; start in any other state SHALL be ignored.
REQ-017 CLEAR SHALL last 1 cycle with cnt_clear=1 and ro_en=0, then go to MEASURE.
REQ-018 MEASURE SHALL last exactly WINDOW cycles with ro_en=1, using a 16-bit window counter that resets on entry, then go to SYNC.
REQ-019 SYNC SHALL last exactly SYNC_CYC cycles with ro_en=0, then go to CAPTURE.
REQ-020 CAPTURE SHALL last 1 cycle and store cnt_value into result[ro_sel].
REQ-021 From CAPTURE, if ro_sel==NUM_RO-1 the FSM SHALL go to DONE; otherwise it SHALL increment ro_sel and go to CLEAR.
REQ-022 ro_sel SHALL never exceed NUM_RO-1, and no oscillator index SHALL be skipped or repeated within a run.
REQ-023 On DONE entry, response[i-1] SHALL equal (result[i] > result[i-1]) for i=1..NUM_RO-1, with equal counts giving 0.
REQ-024 response SHALL be registered and held until the next accepted start.
REQ-025 done SHALL be 1 only in DONE, and busy SHALL be 1 in CLEAR, MEASURE, SYNC and CAPTURE.
REQ-026 ro_en SHALL be 1 only in MEASURE, so that at most one oscillator is enabled at any time.
REQ-027 ro_challenge SHALL stay constant from accepted start until the next accepted start.
REQ-028 Run latency from start to done SHALL be NUM_RO*(WINDOW+SYNC_CYC+2)+1 cycles.
REQ-029 A change of challenge during a run SHALL have no effect on the run.

Reset
REQ-030 Asserting reset SHALL immediately force state IDLE, ro_en=0, cnt_clear=0, ro_sel=0, busy=0, done=0, response=0, ro_challenge=0, window counter=0 and all result entries=0.
REQ-031 Reset mid-run SHALL abort the run with no partial response ever presented; the first start after reset release SHALL begin a full run from ro_sel=0.

Structure
REQ-032 Package ro_puf_pkg SHALL hold NUM_RO_DEF, CNT_W=16, CHAL_W=8 and the FSM state enum type.
REQ-033 The block SHALL contain no sub-modules; the result array and comparators SHALL be inline, with the edge counter and oscillators external.

Verification
REQ-034 Basic run: WINDOW=16, SYNC_CYC=2, a counter model returning 10*(idx+1), start -> done at cycle 181, response=8'hFF.
REQ-035 Descending counts 100-idx -> response=8'h00; all counts equal to 50 -> response=8'h00.
REQ-036 Alternating counts 5,9,5,9,... -> response=8'h55, with ro_sel sequence 0..8 each held 20 cycles.
REQ-037 start asserted mid-MEASURE with a changed challenge -> ignored, ro_challenge unchanged, total latency unchanged.
REQ-038 reset asserted in MEASURE of ro_sel=4 -> ro_en=0 and busy=0 immediately, response=0; next start completes a correct full run.
REQ-039 Bench assertions: ro_en is never 1 outside MEASURE; cnt_clear is one cycle wide and precedes every MEASURE.
